yarp_decode_pipe: RTL and testbench

//  Registered, flow-controlled RV32I/RV64I decode stage between fetch and execute.

---
 rtl/yarp_pkg.sv | 47 ++++
 rtl/yarp_imm_gen.sv | 83 ++++++++
 rtl/yarp_decode_pipe.sv | 132 +++++++++++++
 tb/tb_yarp_decode_pipe.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/yarp_pkg.sv
// Shared decode-stage types: opcode map, FSM states and the decoded packet.
// YARP_XLEN sets the packet width for the build and must equal the stage's XLEN.
package yarp_pkg;

  localparam int YARP_XLEN = 32;

  typedef enum logic [6:0] {
    OP_LOAD   = 7'h03,
    OP_FENCE  = 7'h0F,
    OP_IMM    = 7'h13,
    OP_AUIPC  = 7'h17,
    OP_IMM32  = 7'h1B,
    OP_STORE  = 7'h23,
    OP_OP     = 7'h33,
    OP_LUI    = 7'h37,
    OP_32     = 7'h3B,
    OP_BRANCH = 7'h63,
    OP_JALR   = 7'h67,
    OP_JAL    = 7'h6F,
    OP_SYSTEM = 7'h73
  } opcode_e;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } dec_state_e;

  typedef struct packed {
    logic [4:0]           rs1;
    logic [4:0]           rs2;
    logic [4:0]           rd;
    logic [6:0]           opcode;
    logic [2:0]           funct3;
    logic [6:0]           funct7;
    logic                 r_type;
    logic                 i_type;
    logic                 s_type;
    logic                 b_type;
    logic                 u_type;
    logic                 j_type;
    logic                 illegal;
    logic [YARP_XLEN-1:0] imm;
    logic [YARP_XLEN-1:0] pc;
  } decode_pkt_t;

endpackage

// File: rtl/yarp_imm_gen.sv
// Combinational instruction classifier: type flags, illegal flag and
// sign-extended immediate. Illegal encodings force all flags and imm to zero.
module yarp_imm_gen
  import yarp_pkg::*;
#(
  parameter int XLEN = YARP_XLEN
) (
  input  logic [31:0]     i_instr,
  output logic            o_r_type,
  output logic            o_i_type,
  output logic            o_s_type,
  output logic            o_b_type,
  output logic            o_u_type,
  output logic            o_j_type,
  output logic            o_illegal,
  output logic [XLEN-1:0] o_imm
);

  logic [31:0] w_imm32;

  always_comb begin
    o_r_type  = 1'b0;
    o_i_type  = 1'b0;
    o_s_type  = 1'b0;
    o_b_type  = 1'b0;
    o_u_type  = 1'b0;
    o_j_type  = 1'b0;
    o_illegal = 1'b0;
    w_imm32   = '0;
    case (i_instr[6:0])
      OP_OP: o_r_type = 1'b1;
      OP_LOAD, OP_IMM, OP_JALR: begin
        o_i_type = 1'b1;
        w_imm32  = {{20{i_instr[31]}}, i_instr[31:20]};
      end
      OP_STORE: begin
        o_s_type = 1'b1;
        w_imm32  = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
      end
      OP_BRANCH: begin
        o_b_type = 1'b1;
        w_imm32  = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                    i_instr[30:25], i_instr[11:8], 1'b0};
      end
      OP_LUI, OP_AUIPC: begin
        o_u_type = 1'b1;
        w_imm32  = {i_instr[31:12], 12'h000};
      end
      OP_JAL: begin
        o_j_type = 1'b1;
        w_imm32  = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12],
                    i_instr[20], i_instr[30:21], 1'b0};
      end
      OP_SYSTEM, OP_FENCE: ;
      // Word-sized ops only exist on RV64.
      OP_IMM32: begin
        if (XLEN == 64) begin
          o_i_type = 1'b1;
          w_imm32  = {{20{i_instr[31]}}, i_instr[31:20]};
        end else begin
          o_illegal = 1'b1;
        end
      end
      OP_32: begin
        if (XLEN == 64) o_r_type = 1'b1;
        else            o_illegal = 1'b1;
      end
      default: o_illegal = 1'b1;
    endcase
    if (i_instr[1:0] != 2'b11) o_illegal = 1'b1;
    if (o_illegal) begin
      o_r_type = 1'b0;
      o_i_type = 1'b0;
      o_s_type = 1'b0;
      o_b_type = 1'b0;
      o_u_type = 1'b0;
      o_j_type = 1'b0;
      w_imm32  = '0;
    end
    o_imm = XLEN'($signed(w_imm32));
  end

endmodule

// File: rtl/yarp_decode_pipe.sv
// Registered decode stage between fetch and execute with a 2-entry skid
// buffer, flush, and a count of packets handed to execute.
module yarp_decode_pipe
  import yarp_pkg::*;
#(
  parameter int XLEN    = YARP_XLEN,
  parameter int CNT_W   = 32,
  parameter int SKID_EN = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [31:0]      in_instr_i,
  input  logic [XLEN-1:0]  in_pc_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output decode_pkt_t      out_pkt_o,
  output logic [CNT_W-1:0] dec_cnt_o,
  output dec_state_e       dbg_state_o
);

  // Handshake: a beat moves when valid & ready are both high at a clk edge;
  // valid never waits on ready, and a held packet stays stable until taken.

  dec_state_e       r_state, w_state_nxt;
  decode_pkt_t      r_main, r_skid, w_dec_pkt;
  logic             r_in_ready;
  logic [CNT_W-1:0] r_dec_cnt;
  logic             w_in_ready, w_out_valid, w_in_xfer, w_out_xfer;
  logic             w_load_main, w_main_from_skid, w_load_skid;
  logic             w_r, w_i, w_s, w_b, w_u, w_j, w_illegal;
  logic [XLEN-1:0]  w_imm;

  yarp_imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .i_instr   (in_instr_i),
    .o_r_type  (w_r),
    .o_i_type  (w_i),
    .o_s_type  (w_s),
    .o_b_type  (w_b),
    .o_u_type  (w_u),
    .o_j_type  (w_j),
    .o_illegal (w_illegal),
    .o_imm     (w_imm)
  );

  always_comb begin
    w_dec_pkt         = '0;
    w_dec_pkt.rs1     = in_instr_i[19:15];
    w_dec_pkt.rs2     = in_instr_i[24:20];
    w_dec_pkt.rd      = in_instr_i[11:7];
    w_dec_pkt.opcode  = in_instr_i[6:0];
    w_dec_pkt.funct3  = in_instr_i[14:12];
    w_dec_pkt.funct7  = in_instr_i[31:25];
    w_dec_pkt.r_type  = w_r;
    w_dec_pkt.i_type  = w_i;
    w_dec_pkt.s_type  = w_s;
    w_dec_pkt.b_type  = w_b;
    w_dec_pkt.u_type  = w_u;
    w_dec_pkt.j_type  = w_j;
    w_dec_pkt.illegal = w_illegal;
    w_dec_pkt.imm     = w_imm;
    w_dec_pkt.pc      = in_pc_i;
  end

  assign w_out_valid = (r_state != ST_EMPTY);
  // Without the skid entry, ready must look through to the consumer.
  assign w_in_ready  = (SKID_EN != 0) ? r_in_ready : (!w_out_valid || out_ready_i);
  assign w_in_xfer   = in_valid_i && w_in_ready;
  assign w_out_xfer  = w_out_valid && out_ready_i;

  always_comb begin
    w_state_nxt      = r_state;
    w_load_main      = 1'b0;
    w_main_from_skid = 1'b0;
    w_load_skid      = 1'b0;
    if (flush_i) begin
      w_state_nxt = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_in_xfer) begin
            w_load_main = 1'b1;
            w_state_nxt = ST_FULL;
          end
        end
        ST_FULL: begin
          if (w_in_xfer && w_out_xfer) begin
            w_load_main = 1'b1;
          end else if (w_in_xfer) begin
            w_load_skid = 1'b1;
            w_state_nxt = ST_SKID;
          end else if (w_out_xfer) begin
            w_state_nxt = ST_EMPTY;
          end
        end
        ST_SKID: begin
          if (w_out_xfer) begin
            w_main_from_skid = 1'b1;
            w_state_nxt      = ST_FULL;
          end
        end
        default: w_state_nxt = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state    <= ST_EMPTY;
      r_main     <= '0;
      r_skid     <= '0;
      r_in_ready <= 1'b1;
      r_dec_cnt  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_in_ready <= (w_state_nxt != ST_SKID);
      if (w_load_main)      r_main <= w_dec_pkt;
      if (w_main_from_skid) r_main <= r_skid;
      if (w_load_skid)      r_skid <= w_dec_pkt;
      if (w_out_xfer)       r_dec_cnt <= r_dec_cnt + CNT_W'(1);
    end
  end

  assign in_ready_o  = w_in_ready;
  assign out_valid_o = w_out_valid;
  assign out_pkt_o   = r_main;
  assign dec_cnt_o   = r_dec_cnt;
  assign dbg_state_o = r_state;

endmodule

// File: tb/tb_yarp_decode_pipe.sv
// Directed bench for yarp_decode_pipe: decode vector table plus hand-written
// streaming, backpressure, flush, reset and counter-wrap sequences.
module tb_yarp_decode_pipe;
  import yarp_pkg::*;

  logic        clk;
  logic        reset_n;
  logic        flush_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [31:0] in_instr_i;
  logic [31:0] in_pc_i;
  logic        out_valid_o;
  logic        out_ready_i;
  decode_pkt_t out_pkt_o;
  logic [3:0]  dec_cnt_o;
  dec_state_e  dbg_state_o;

  yarp_decode_pipe #(.XLEN(32), .CNT_W(4), .SKID_EN(1)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .flush_i     (flush_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_instr_i  (in_instr_i),
    .in_pc_i     (in_pc_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_pkt_o   (out_pkt_o),
    .dec_cnt_o   (dec_cnt_o),
    .dbg_state_o (dbg_state_o)
  );

  // clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // scoreboard
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_q[$];
  logic [3:0]  exp_cnt = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Called just after a negedge with inputs already driven; models the edge.
  task automatic cycle();
    logic [31:0] exp_pc;
    #1;
    if (!reset_n) begin
      exp_q.delete();
      exp_cnt = '0;
    end else begin
      if (out_valid_o && out_ready_i) begin
        exp_cnt = exp_cnt + 4'd1;
        if (exp_q.size() == 0) begin
          check("unexpected_out_pc", 64'(out_pkt_o.pc), 64'hDEAD_BEEF);
        end else begin
          exp_pc = exp_q.pop_front();
          check("out_order_pc", 64'(out_pkt_o.pc), 64'(exp_pc));
        end
      end
      if (flush_i) exp_q.delete();
      else if (in_valid_i && in_ready_o) exp_q.push_back(in_pc_i);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic stream(input int n, input logic [31:0] base);
    for (int k = 0; k < n; k++) begin
      in_valid_i  = 1'b1;
      in_instr_i  = 32'h0000_0013 | (32'(k[4:0]) << 7);
      in_pc_i     = base + 32'(4 * k);
      out_ready_i = 1'b1;
      check($sformatf("stream_in_ready_%0d", k), 64'(in_ready_o), 64'd1);
      if (k > 0) begin
        check($sformatf("stream_no_bubble_%0d", k), 64'(out_valid_o), 64'd1);
      end
      cycle();
    end
    in_valid_i = 1'b0;
    cycle();
  endtask

  typedef struct {
    logic [31:0] instr;
    logic [5:0]  flags;  // {r,i,s,b,u,j}
    logic        ill;
    logic [31:0] imm;
  } vec_t;

  vec_t vecs[16];

  initial begin
    int guard;
    logic [3:0] cnt_before;

    vecs[0]  = '{32'hFFF0_0093, 6'b010000, 1'b0, 32'hFFFF_FFFF};
    vecs[1]  = '{32'h8000_00EF, 6'b000001, 1'b0, 32'hFFF0_0000};
    vecs[2]  = '{32'h1234_5037, 6'b000010, 1'b0, 32'h1234_5000};
    vecs[3]  = '{32'h0000_0000, 6'b000000, 1'b1, 32'h0000_0000};
    vecs[4]  = '{32'hFFFF_FFFF, 6'b000000, 1'b1, 32'h0000_0000};
    vecs[5]  = '{32'h0000_0073, 6'b000000, 1'b0, 32'h0000_0000};
    vecs[6]  = '{32'h0000_000F, 6'b000000, 1'b0, 32'h0000_0000};
    vecs[7]  = '{32'h0020_81B3, 6'b100000, 1'b0, 32'h0000_0000};
    vecs[8]  = '{32'hFE20_AE23, 6'b001000, 1'b0, 32'hFFFF_FFFC};
    vecs[9]  = '{32'h0020_8863, 6'b000100, 1'b0, 32'h0000_0010};
    vecs[10] = '{32'h0000_8067, 6'b010000, 1'b0, 32'h0000_0000};
    vecs[11] = '{32'hFFFF_F117, 6'b000010, 1'b0, 32'hFFFF_F000};
    vecs[12] = '{32'h0000_001B, 6'b000000, 1'b1, 32'h0000_0000};
    vecs[13] = '{32'h0000_0010, 6'b000000, 1'b1, 32'h0000_0000};
    vecs[14] = '{32'h0010_0073, 6'b000000, 1'b0, 32'h0000_0000};
    vecs[15] = '{32'h0000_0003, 6'b010000, 1'b0, 32'h0000_0000};

    // reset
    reset_n = 1'b0; flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0;
    in_instr_i = '0; in_pc_i = '0;
    @(negedge clk);
    cycle();
    cycle();
    reset_n = 1'b1;
    check("rst_out_valid", 64'(out_valid_o), 64'd0);
    check("rst_in_ready",  64'(in_ready_o),  64'd1);
    check("rst_dec_cnt",   64'(dec_cnt_o),   64'd0);
    check("rst_pkt_pc",    64'(out_pkt_o.pc), 64'd0);
    check("rst_pkt_imm",   64'(out_pkt_o.imm), 64'd0);
    check("rst_state",     64'(dbg_state_o), 64'(ST_EMPTY));

    // streaming: 8 back-to-back with 1-cycle latency
    in_valid_i = 1'b1; in_instr_i = 32'h0000_0013; in_pc_i = 32'h0000_1000; out_ready_i = 1'b1;
    cycle();
    in_valid_i = 1'b0;
    check("latency_valid", 64'(out_valid_o), 64'd1);
    check("latency_pc",    64'(out_pkt_o.pc), 64'h1000);
    cycle();
    stream(7, 32'h0000_1004);
    check("stream_dec_cnt",   64'(dec_cnt_o),   64'd8);
    check("stream_out_valid", 64'(out_valid_o), 64'd0);

    // backpressure: two accepted, third held off, order kept on release
    out_ready_i = 1'b0; in_valid_i = 1'b1;
    in_pc_i = 32'h0000_2000; cycle();
    in_pc_i = 32'h0000_2004; cycle();
    check("bp_in_ready_low", 64'(in_ready_o),  64'd0);
    check("bp_state_skid",   64'(dbg_state_o), 64'(ST_SKID));
    check("bp_head_pc",      64'(out_pkt_o.pc), 64'h2000);
    in_pc_i = 32'h0000_2008; cycle();
    check("bp_stable_pc",    64'(out_pkt_o.pc), 64'h2000);
    check("bp_stable_ready", 64'(in_ready_o),  64'd0);
    out_ready_i = 1'b1;
    guard = 0;
    while (guard < 10) begin
      guard++;
      if (in_ready_o) begin
        cycle();
        break;
      end
      cycle();
    end
    in_valid_i = 1'b0;
    guard = 0;
    while (out_valid_o && guard < 10) begin
      guard++;
      cycle();
    end
    check("bp_drained",   64'(out_valid_o), 64'd0);
    check("bp_queue_empty", 64'(exp_q.size()), 64'd0);
    check("bp_dec_cnt",   64'(dec_cnt_o), 64'd11);

    // flush from SKID with an input beat offered in the same cycle
    out_ready_i = 1'b0; in_valid_i = 1'b1;
    in_pc_i = 32'h0000_3000; cycle();
    in_pc_i = 32'h0000_3004; cycle();
    check("fl_state_skid", 64'(dbg_state_o), 64'(ST_SKID));
    flush_i = 1'b1; in_pc_i = 32'h0000_3008; cycle();
    flush_i = 1'b0; in_valid_i = 1'b0;
    check("fl_out_valid", 64'(out_valid_o), 64'd0);
    check("fl_in_ready",  64'(in_ready_o),  64'd1);
    check("fl_state",     64'(dbg_state_o), 64'(ST_EMPTY));
    out_ready_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("fl_quiet_%0d", k), 64'(out_valid_o), 64'd0);
      cycle();
    end

    // flush coinciding with an output transfer still counts it
    cnt_before = dec_cnt_o;
    out_ready_i = 1'b0; in_valid_i = 1'b1; in_pc_i = 32'h0000_3100; cycle();
    in_valid_i = 1'b0; flush_i = 1'b1; out_ready_i = 1'b1; cycle();
    flush_i = 1'b0;
    check("fl_out_counts", 64'(dec_cnt_o), 64'(4'(cnt_before + 4'd1)));
    check("fl_out_valid2", 64'(out_valid_o), 64'd0);

    // decode table
    foreach (vecs[i]) begin
      in_valid_i = 1'b1; out_ready_i = 1'b1;
      in_instr_i = vecs[i].instr; in_pc_i = 32'h0000_5000 + 32'(4 * i);
      cycle();
      in_valid_i = 1'b0;
      check($sformatf("vec%0d_valid", i), 64'(out_valid_o), 64'd1);
      check($sformatf("vec%0d_flags", i),
            64'({out_pkt_o.r_type, out_pkt_o.i_type, out_pkt_o.s_type,
                 out_pkt_o.b_type, out_pkt_o.u_type, out_pkt_o.j_type}),
            64'(vecs[i].flags));
      check($sformatf("vec%0d_illegal", i), 64'(out_pkt_o.illegal), 64'(vecs[i].ill));
      check($sformatf("vec%0d_imm", i), 64'(out_pkt_o.imm), 64'(vecs[i].imm));
      check($sformatf("vec%0d_opcode", i), 64'(out_pkt_o.opcode), 64'(vecs[i].instr & 32'h7F));
      cycle();
    end
    check("vec_rd_field", 64'(out_pkt_o.rd), 64'd0);

    // reset mid-stream drops held instructions and clears the counter
    out_ready_i = 1'b0; in_valid_i = 1'b1; in_instr_i = 32'h0000_0013;
    in_pc_i = 32'h0000_4000; cycle();
    in_pc_i = 32'h0000_4004; cycle();
    reset_n = 1'b0; in_pc_i = 32'h0000_4008; cycle();
    reset_n = 1'b1; in_valid_i = 1'b0;
    check("mrst_out_valid", 64'(out_valid_o), 64'd0);
    check("mrst_in_ready",  64'(in_ready_o),  64'd1);
    check("mrst_dec_cnt",   64'(dec_cnt_o),   64'd0);
    check("mrst_pkt_pc",    64'(out_pkt_o.pc), 64'd0);
    out_ready_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("mrst_quiet_%0d", k), 64'(out_valid_o), 64'd0);
      cycle();
    end

    // counter wrap: 17 transfers on a 4-bit counter
    stream(17, 32'h0000_6000);
    check("wrap_dec_cnt", 64'(dec_cnt_o), 64'd1);
    check("wrap_model_cnt", 64'(dec_cnt_o), 64'(exp_cnt));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
